// File: rtl/morph_pkg.sv
// Shared mode/state encodings and the 3x3 window reduction used by image_morphology.
package morph_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS     = 2'b00,
    MODE_DILATE     = 2'b01,
    MODE_ERODE      = 2'b10,
    MODE_BYPASS_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam int MAX_PX_W = 32;
  localparam int TAPS     = 9;
  localparam int CENTRE   = 4;

  typedef logic [MAX_PX_W-1:0] px_t;

  // Taps are row-major (0 = top-left); only taps flagged in 'valid' take part.
  function automatic px_t window_op(input logic [TAPS-1:0][MAX_PX_W-1:0] win,
                                    input logic [TAPS-1:0]               valid,
                                    input mode_e                         op);
    px_t res;
    res = win[CENTRE];
    for (int i = 0; i < TAPS; i++) begin
      if (valid[i]) begin
        if (op == MODE_DILATE && win[i] > res) res = win[i];
        if (op == MODE_ERODE && win[i] < res) res = win[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Row delay: the value sampled on dout at an enabled clock is din from DEPTH enabled clocks earlier.
module morph_line_buffer #(
  parameter int DEPTH = 520,
  parameter int PX_W  = 1
) (
  input  logic            CLK100MHZ,
  input  logic            en,
  input  logic [PX_W-1:0] din,
  output logic [PX_W-1:0] dout
);
  // The registered read supplies one stage of the delay, so the array holds DEPTH-1 entries.
  localparam int N  = DEPTH - 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [PX_W-1:0] mem [N];
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [PX_W-1:0] dout_q;

  always_comb begin
    ptr_d = (ptr_q == AW'(N - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (en) begin
      mem[ptr_q] <= din;
      dout_q     <= mem[ptr_q];
      ptr_q      <= ptr_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/image_morphology.sv
// Streaming 3x3 dilate/erode/bypass over a raster image with edge-excluding borders.
module image_morphology
  import morph_pkg::*;
#(
  parameter int PX_PER_ROW = 520,
  parameter int IMG_ROWS   = 390,
  parameter int PX_W       = 1
) (
  input  logic            CLK100MHZ,
  input  logic            btn_reset_n,
  input  logic            ena,
  input  logic            sof,
  input  logic [PX_W-1:0] next_px,
  input  logic [1:0]      mode,
  output logic [PX_W-1:0] output_px,
  output logic            out_valid,
  output logic            out_eof,
  output logic            busy
);
  localparam int CW = $clog2(PX_PER_ROW);
  localparam int RW = $clog2(IMG_ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(PX_PER_ROW - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_ROWS - 1);

  state_e                   state_q, state_d;
  mode_e                    mode_q, mode_d;
  logic [CW-1:0]            in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0]            in_row_q, in_row_d, out_row_q, out_row_d;
  logic [2:0][2:0][PX_W-1:0] win_q, win_d;
  logic [PX_W-1:0]          output_px_q, output_px_d;
  logic                     out_valid_q, out_valid_d, out_eof_q, out_eof_d;

  logic accept, start, advance, produce, last_in, last_out;
  logic [PX_W-1:0] lb_mid_dout, lb_top_dout, filt_px;
  logic [2:0] row_ok, col_ok;
  logic [TAPS-1:0][MAX_PX_W-1:0] taps;
  logic [TAPS-1:0] tap_valid;

  assign busy     = (state_q == ST_FLUSH);
  assign accept   = ena && !busy;
  assign start    = accept && sof;
  // FLUSH keeps the window moving with don't-care pixels; the border masks hide them.
  assign advance  = (accept && (state_q != ST_IDLE || sof)) || busy;
  assign produce  = (state_q == ST_RUN && accept && !sof) || busy;
  assign last_in  = (in_row_q == LAST_ROW) && (in_col_q == LAST_COL);
  assign last_out = (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);

  morph_line_buffer #(.DEPTH(PX_PER_ROW), .PX_W(PX_W)) u_lb_mid (
    .CLK100MHZ(CLK100MHZ), .en(advance), .din(next_px), .dout(lb_mid_dout)
  );
  morph_line_buffer #(.DEPTH(PX_PER_ROW), .PX_W(PX_W)) u_lb_top (
    .CLK100MHZ(CLK100MHZ), .en(advance), .din(lb_mid_dout), .dout(lb_top_dout)
  );

  // Newest column enters at [*][2]; after the shift the centre tap is the pixel being output.
  always_comb begin
    win_d = win_q;
    if (advance) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_top_dout;
      win_d[1][2] = lb_mid_dout;
      win_d[2][2] = next_px;
    end
  end

  assign row_ok = {out_row_q != LAST_ROW, 1'b1, out_row_q != '0};
  assign col_ok = {out_col_q != LAST_COL, 1'b1, out_col_q != '0};

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    assign taps[gi]      = MAX_PX_W'(win_d[gi / 3][gi % 3]);
    assign tap_valid[gi] = row_ok[gi / 3] & col_ok[gi % 3];
  end

  assign filt_px = PX_W'(window_op(taps, tap_valid, mode_q));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    output_px_d = output_px_q;
    out_valid_d = 1'b0;
    out_eof_d   = 1'b0;
    if (start) begin
      state_d   = ST_FILL;
      mode_d    = mode_e'(mode);
      in_col_d  = CW'(1);
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end else if (accept && (state_q == ST_FILL || state_q == ST_RUN)) begin
      in_col_d = (in_col_q == LAST_COL) ? '0 : in_col_q + 1'b1;
      if (in_col_q == LAST_COL) in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + 1'b1;
      if (state_q == ST_FILL && in_row_q == RW'(1) && in_col_q == '0) state_d = ST_RUN;
      if (state_q == ST_RUN && last_in) state_d = ST_FLUSH;
    end
    if (produce) begin
      out_valid_d = 1'b1;
      out_eof_d   = last_out;
      output_px_d = filt_px;
      out_col_d   = (out_col_q == LAST_COL) ? '0 : out_col_q + 1'b1;
      if (out_col_q == LAST_COL) out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + 1'b1;
      if (busy && last_out) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge btn_reset_n) begin
    if (!btn_reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BYPASS;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      win_q       <= '0;
      output_px_q <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      win_q       <= win_d;
      output_px_q <= output_px_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign output_px = output_px_q;
  assign out_valid = out_valid_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_image_morphology.sv
// Self-checking bench for image_morphology on an 8x4 image with a window-level reference model.
module tb_image_morphology;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int PXW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           sof = 1'b0;
  logic [PXW-1:0] next_px = '0;
  logic [1:0]     mode = '0;
  logic [PXW-1:0] output_px;
  logic           out_valid, out_eof, busy;

  image_morphology #(.PX_PER_ROW(W), .IMG_ROWS(H), .PX_W(PXW)) dut (
    .CLK100MHZ(clk), .btn_reset_n(rst_n), .ena(ena), .sof(sof), .next_px(next_px),
    .mode(mode), .output_px(output_px), .out_valid(out_valid), .out_eof(out_eof), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int px;
    bit eof;
  } exp_t;

  exp_t exp_q[$];
  int img_in[N];
  int exp_img[N];
  int checks = 0, errors = 0;
  int valid_cnt = 0, busy_cnt = 0;
  int acc9_cyc = -1, first_valid_cyc = -1;
  bit done = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: each output is the max/min over the in-image part of its 3x3 neighbourhood.
  function automatic void compute_model(input int md);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int acc;
        acc = img_in[r*W + c];
        if (md == 1 || md == 2) begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int rr, cc, v;
              rr = r + dr;
              cc = c + dc;
              if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                v = img_in[rr*W + cc];
                if (md == 1 && v > acc) acc = v;
                if (md == 2 && v < acc) acc = v;
              end
            end
          end
        end
        exp_img[r*W + c] = acc;
      end
    end
  endfunction

  function automatic int count_val(input int v);
    int n = 0;
    for (int i = 0; i < N; i++) if (exp_img[i] == v) n++;
    return n;
  endfunction

  task automatic push_exp(input int first, input int count, input bit with_eof);
    for (int i = first; i < first + count; i++) begin
      exp_t e;
      e.px  = exp_img[i];
      e.eof = with_eof && (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_frame(input int n, input int gap_pct, input logic [1:0] md, input bit mark9);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4000) begin
      @(negedge clk); #1;
      guard++;
      if (int'($urandom_range(99)) < gap_pct) begin
        ena = 1'b0;
        sof = 1'b0;
        next_px = 8'($urandom_range(255));
        mode = 2'($urandom_range(3));
      end else begin
        ena = 1'b1;
        sof = (i == 0);
        next_px = 8'(img_in[i]);
        mode = (i == 0) ? md : 2'($urandom_range(3));
        if (mark9 && i == 9) acc9_cyc = cyc;
        i++;
      end
    end
    chk("drive_budget", i, n);
    @(negedge clk); #1;
    ena = 1'b0;
    sof = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 300) begin
      @(negedge clk); #2;
      guard++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", int'({output_px, out_valid, out_eof, busy}), 0);
      end else begin
        if (busy) busy_cnt++;
        if (out_valid) begin
          valid_cnt++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", int'(out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("output_px", int'(output_px), e.px);
            chk("out_eof", int'(out_eof), int'(e.eof));
          end
        end else begin
          chk("out_eof_without_valid", int'(out_eof), 0);
        end
      end
    end
  endtask

  task automatic load_single(input int r, input int c, input int bg, input int fg);
    for (int i = 0; i < N; i++) img_in[i] = bg;
    img_in[r*W + c] = fg;
  endtask

  task automatic main_seq();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #2;
    chk("idle_busy", int'(busy), 0);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_output_px", int'(output_px), 0);

    // Dilate, single 1 at (1,3)
    load_single(1, 3, 0, 1);
    compute_model(1);
    chk("model_dil_r0c2", exp_img[0*W + 2], 1);
    chk("model_dil_r2c4", exp_img[2*W + 4], 1);
    chk("model_dil_r3c3", exp_img[3*W + 3], 0);
    chk("model_dil_r1c5", exp_img[1*W + 5], 0);
    chk("model_dil_ones", count_val(1), 9);
    valid_cnt = 0;
    push_exp(0, N, 1'b1);
    drive_frame(N, 0, 2'b01, 1'b0);
    wait_done("dilate");
    chk("dilate_valid_count", valid_cnt, N);

    // Erode, all ones except (2,5)
    load_single(2, 5, 1, 0);
    compute_model(2);
    chk("model_ero_r1c4", exp_img[1*W + 4], 0);
    chk("model_ero_r3c6", exp_img[3*W + 6], 0);
    chk("model_ero_r0c5", exp_img[0*W + 5], 1);
    chk("model_ero_r3c7", exp_img[3*W + 7], 1);
    chk("model_ero_r1c3", exp_img[1*W + 3], 1);
    chk("model_ero_zeros", count_val(0), 9);
    valid_cnt = 0;
    push_exp(0, N, 1'b1);
    drive_frame(N, 0, 2'b10, 1'b0);
    wait_done("erode");
    chk("erode_valid_count", valid_cnt, N);

    // Bypass ramp: latency and flush length
    for (int i = 0; i < N; i++) img_in[i] = i + 1;
    compute_model(0);
    chk("model_byp_k17", exp_img[17], 18);
    valid_cnt = 0;
    busy_cnt = 0;
    first_valid_cyc = -1;
    push_exp(0, N, 1'b1);
    drive_frame(N, 0, 2'b00, 1'b1);
    wait_done("bypass");
    chk("bypass_valid_count", valid_cnt, N);
    chk("bypass_first_valid_after_idx9", first_valid_cyc - acc9_cyc, 1);
    chk("bypass_busy_cycles", busy_cnt, W + 1);

    // Dilate image again with ~50% ena gaps
    load_single(1, 3, 0, 1);
    compute_model(1);
    valid_cnt = 0;
    push_exp(0, N, 1'b1);
    drive_frame(N, 50, 2'b01, 1'b0);
    wait_done("gaps");
    chk("gaps_valid_count", valid_cnt, N);

    // Abort frame 1 at index 13; frame 2 in mode 11 (bypass)
    for (int i = 0; i < N; i++) img_in[i] = int'($urandom_range(1));
    compute_model(1);
    valid_cnt = 0;
    push_exp(0, 4, 1'b0);
    drive_frame(13, 0, 2'b01, 1'b0);
    for (int i = 0; i < N; i++) img_in[i] = int'($urandom_range(255));
    compute_model(3);
    push_exp(0, N, 1'b1);
    drive_frame(N, 0, 2'b11, 1'b0);
    wait_done("abort");
    chk("abort_valid_count", valid_cnt, 4 + N);

    // Greyscale dilate and erode
    for (int i = 0; i < N; i++) img_in[i] = int'($urandom_range(255));
    compute_model(1);
    valid_cnt = 0;
    push_exp(0, N, 1'b1);
    drive_frame(N, 25, 2'b01, 1'b0);
    wait_done("grey_dilate");
    compute_model(2);
    push_exp(0, N, 1'b1);
    drive_frame(N, 25, 2'b10, 1'b0);
    wait_done("grey_erode");
    chk("grey_valid_count", valid_cnt, 2 * N);

    // Reset pulse after index 20 (outputs 0..11 already produced)
    for (int i = 0; i < N; i++) img_in[i] = int'($urandom_range(255));
    compute_model(1);
    push_exp(0, 12, 1'b0);
    drive_frame(21, 0, 2'b01, 1'b0);
    rst_n = 1'b0;
    chk("midrun_outputs_seen", exp_q.size(), 0);
    #1;
    chk("reset_async_out_valid", int'(out_valid), 0);
    chk("reset_async_output_px", int'(output_px), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    valid_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      ena = 1'b1;
      sof = 1'b0;
      next_px = 8'($urandom_range(255));
      @(negedge clk); #2;
      chk("post_reset_busy", int'(busy), 0);
    end
    ena = 1'b0;
    chk("post_reset_no_outputs", valid_cnt, 0);
    compute_model(2);
    push_exp(0, N, 1'b1);
    drive_frame(N, 0, 2'b10, 1'b0);
    wait_done("after_reset");
    chk("after_reset_valid_count", valid_cnt, N);

    repeat (3) @(negedge clk);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_morphology.md
IMAGE_MORPHOLOGY -- requirements
Module: image_morphology

Interface
REQ-001 The block SHALL have parameter PX_PER_ROW, default 520, meaning image width in pixels (W), minimum 3.
REQ-002 The block SHALL have parameter IMG_ROWS, default 390, meaning image height in rows (H), minimum 3.
REQ-003 The block SHALL have parameter PX_W, default 1, meaning pixel width in bits (1 = binary, >1 = greyscale).
REQ-004 CLK100MHZ  in  1  single clock; all logic on its rising edge.
REQ-005 btn_reset_n  in  1  asynchronous, active-low reset.
REQ-006 ena  in  1  input pixel strobe; next_px and sof are accepted only on clocks with ena=1 and busy=0.
REQ-007 sof  in  1  marks the accepted pixel as frame index 0.
REQ-008 next_px  in  PX_W  input pixel, raster order.
REQ-009 mode  in  2  00 bypass, 01 dilate, 10 erode, 11 treated as bypass; sampled only with an accepted sof.
REQ-010 output_px  out  PX_W  filtered pixel, registered.
REQ-011 out_valid  out  1  output_px valid this clock.
REQ-012 out_eof  out  1  high with out_valid on the frame's last output pixel, index W*H-1.
REQ-013 busy  out  1  high in FLUSH; inputs are ignored while high.

Function
REQ-014 Dilate: output(r,c) SHALL be the unsigned max of the in-image pixels of the 3x3 window centred on (r,c).
REQ-015 Erode: output(r,c) SHALL be the unsigned min of that window; out-of-image neighbours are excluded, i.e. no padding at edges.
REQ-016 Bypass: output(r,c) SHALL equal input(r,c), with the same timing as the filter modes.
REQ-017 Output index k = r*W+c SHALL be registered one clock after input index k+W+1 is accepted; when k+W+1 >= W*H it is produced during FLUSH.
REQ-018 States SHALL be IDLE, FILL, RUN and FLUSH.
- IDLE: waits for an accepted sof.
- FILL: accepts indices 0..W; no output.
- RUN: one output per accepted pixel.
- FLUSH: W+1 clocks; one output per clock.
REQ-019 Transitions:
- IDLE->FILL on an accepted sof.
- FILL->RUN after index W is accepted.
- RUN->FLUSH after index W*H-1 is accepted.
- FLUSH->IDLE after W+1 outputs.
REQ-020 Accepted pixels in IDLE without sof SHALL be ignored.
REQ-021 ena=0 SHALL freeze all state, counters and line buffers outside FLUSH; out_valid is 0 on such clocks.
REQ-022 An accepted sof in FILL or RUN SHALL abort the frame and restart at index 0 with this pixel; no further outputs or out_eof are produced for the aborted frame.
REQ-023 sof during FLUSH SHALL be ignored, because busy=1 blocks acceptance.
REQ-024 The column counter SHALL wrap W-1->0, incrementing the row counter; the row counter spans 0..H-1.
REQ-025 Both counters SHALL be $clog2-sized, with no overflow at W*H.
REQ-026 The two line buffers SHALL each delay by exactly W accepted pixels; stale contents at frame start SHALL be masked by the border logic.
REQ-027 Exactly W*H out_valid pulses SHALL occur per completed frame.

Reset
REQ-028 On btn_reset_n=0: state IDLE; counters 0; output_px=0, out_valid=0, out_eof=0, busy=0; latched mode = bypass; window registers 0.
REQ-029 Line-buffer contents SHALL NOT require reset.
REQ-030 Reset assertion mid-frame SHALL take effect immediately; after release the block waits for a new sof.

Structure
REQ-031 Package morph_pkg SHALL hold the mode encodings, the state enum and a function returning max/min/centre for a 3x3 window.
REQ-032 Sub-module morph_line_buffer (parameters DEPTH, PX_W; ports CLK100MHZ, en, din, dout) SHALL implement each row delay and be instantiated twice.
REQ-033 Gated clocks SHALL NOT be used; ena acts as a clock enable.

Verification (W=8, H=4 unless noted)
REQ-034 Dilate, PX_W=1, single 1 at (1,3), ena continuous -> 1 at rows 0-2 cols 2-4 (9 pixels), all others 0; 32 out_valid; out_eof on 32nd.
REQ-035 Erode, all ones except (2,5)=0 -> 0 at rows 1-3 cols 4-6, all other pixels 1, including edges.
REQ-036 Bypass, ena continuous, ramp input -> first out_valid one clock after index 9 accepted; busy high 9 clocks; output equals input.
REQ-037 Random ena gaps (~50%) with the scenario REQ-034 image -> output stream identical to the continuous case.
REQ-038 sof reasserted at index 13 of frame 1 -> no out_eof for frame 1; frame 2 produces exactly 32 correct outputs.
REQ-039 PX_W=8, dilate/erode on random image; btn_reset_n pulsed mid-RUN -> matches max/min model before reset; all outputs 0 during reset; IDLE until next sof.
